// File: rtl/inst_axi_rbridge.sv
// Instruction-fetch bridge: converts sram-style read requests into single-beat AXI reads.
// Keeps at most one AR pending and at most two reads outstanding, with data returned in order.
module inst_axi_rbridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [0:0] {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_t;

    ar_state_t   state_r;
    ar_state_t   state_s;
    logic [1:0]  cnt_r;
    logic [1:0]  cnt_s;
    logic [31:0] araddr_r;
    logic [1:0]  arsize_r;
    logic        live_r;
    logic        accept_s;
    logic        read_done_s;
    logic        unused_s;

    // live_r stays low for the first cycle out of reset so the handshakes stay quiet there
    assign inst_sram_addr_ok = resetn & live_r & inst_sram_req & ~inst_sram_wr
                             & (state_r == AR_IDLE) & (cnt_r < 2'd2);
    assign rready            = resetn & live_r & (cnt_r != 2'd0);
    assign inst_sram_data_ok = rvalid & rready & rlast;
    assign inst_sram_rdata   = rdata;

    assign accept_s    = inst_sram_req & inst_sram_addr_ok;
    assign read_done_s = inst_sram_data_ok;

    assign arid    = 4'd0;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign araddr  = araddr_r;
    assign arsize  = {1'b0, arsize_r};
    assign arvalid = (state_r == AR_SEND);

    assign unused_s = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp};

    // AR channel next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            AR_IDLE: begin
                if (accept_s) begin
                    state_s = AR_SEND;
                end else begin
                    state_s = AR_IDLE;
                end
            end
            AR_SEND: begin
                if (arready) begin
                    state_s = AR_IDLE;
                end else begin
                    state_s = AR_SEND;
                end
            end
            default: state_s = AR_IDLE;
        endcase
    end

    // Outstanding-read count; accept and return in one cycle cancel out
    always_comb begin
        cnt_s = cnt_r;
        case ({accept_s, read_done_s})
            2'b10:   cnt_s = cnt_r + 2'd1;
            2'b01:   cnt_s = cnt_r - 2'd1;
            default: cnt_s = cnt_r;
        endcase
    end

    // State, counter and AR payload registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r  <= AR_IDLE;
            cnt_r    <= 2'd0;
            araddr_r <= 32'd0;
            arsize_r <= 2'd0;
            live_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            live_r  <= 1'b1;
            if (accept_s) begin
                araddr_r <= inst_sram_addr;
                arsize_r <= inst_sram_size;
            end else begin
                araddr_r <= araddr_r;
                arsize_r <= arsize_r;
            end
        end
    end

endmodule

// File: tb/tb_inst_axi_rbridge.sv
// Directed bench for inst_axi_rbridge: bench acts as requester and AXI slave,
// expected read data is queued at acceptance and compared in order at data_ok.
module tb_inst_axi_rbridge;

    logic        clk;
    logic        resetn;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks;
    int failures;
    logic [31:0] exp_q[$];

    inst_axi_rbridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare a returned beat against the oldest accepted request
    task automatic chk_return(input string tag);
        logic [31:0] exp;
        chk({tag, "_data_ok"}, {31'd0, inst_sram_data_ok}, 32'd1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk({tag, "_rdata"}, inst_sram_rdata, exp);
        end else begin
            checks++;
            failures++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        resetn = 1'b0;
        inst_sram_req = 1'b1; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
        inst_sram_wstrb = 4'hF; inst_sram_addr = 32'h1C00_0000; inst_sram_wdata = 32'hDEAD_BEEF;
        arready = 1'b0; rid = 4'd3; rdata = 32'd0; rresp = 2'b10; rlast = 1'b0; rvalid = 1'b0;

        // reset state
        repeat (3) tick();
        sample();
        chk("rst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_arconst", {arid, arlen, arburst, arlock, arcache, arprot}, {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        tick();
        resetn = 1'b1;
        sample();
        chk("post_rst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
        tick();

        // single fetch
        inst_sram_addr = 32'h1C00_0000; inst_sram_size = 2'd2;
        sample();
        chk("single_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        exp_q.push_back(32'h0280_0C06);
        tick();
        inst_sram_req = 1'b0; arready = 1'b1;
        sample();
        chk("single_arvalid", {31'd0, arvalid}, 32'd1);
        chk("single_araddr", araddr, 32'h1C00_0000);
        chk("single_arsize", {29'd0, arsize}, 32'd2);
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0280_0C06;
        sample();
        chk_return("single");
        chk("single_ar_done", {31'd0, arvalid}, 32'd0);
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        sample();
        chk("single_rready_idle", {31'd0, rready}, 32'd0);
        tick();

        // AR backpressure
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0010; inst_sram_size = 2'd1;
        sample();
        chk("bp_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        exp_q.push_back(32'h1111_2222);
        tick();
        inst_sram_addr = 32'h1C00_0FF0; inst_sram_size = 2'd2;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("bp_arvalid", {31'd0, arvalid}, 32'd1);
            chk("bp_araddr", araddr, 32'h1C00_0010);
            chk("bp_arsize", {29'd0, arsize}, 32'd1);
            chk("bp_addr_ok_blocked", {31'd0, inst_sram_addr_ok}, 32'd0);
            tick();
        end
        inst_sram_req = 1'b0; arready = 1'b1;
        sample();
        chk("bp_arvalid_hs", {31'd0, arvalid}, 32'd1);
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1111_2222;
        sample();
        chk_return("bp");
        tick();
        rvalid = 1'b0; rlast = 1'b0;

        // two outstanding, full refusal, then simultaneous accept and return at cnt=1
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; inst_sram_size = 2'd2;
        sample();
        chk("two_a_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        exp_q.push_back(32'hAAAA_0001);
        tick();
        inst_sram_req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0004;
        sample();
        chk("two_b_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        exp_q.push_back(32'hAAAA_0002);
        tick();
        inst_sram_req = 1'b0; arready = 1'b1;
        sample();
        chk("two_b_araddr", araddr, 32'h1C00_0004);
        tick();
        arready = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0008;
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'hAAAA_0001;
        sample();
        chk("full_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
        chk_return("full_ret");
        tick();
        rdata = 32'hAAAA_0002;
        sample();
        chk("resume_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        exp_q.push_back(32'hAAAA_0003);
        chk_return("simul_ret");
        tick();
        rvalid = 1'b0; rlast = 1'b0; arready = 1'b1;
        sample();
        chk("simul_araddr", araddr, 32'h1C00_0008);
        chk("simul_send_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
        chk("simul_rready", {31'd0, rready}, 32'd1);
        tick();
        inst_sram_req = 1'b0; arready = 1'b0;
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'hAAAA_0003;
        sample();
        chk_return("simul_last");
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        sample();
        chk("drain_rready", {31'd0, rready}, 32'd0);
        tick();

        // write stall
        inst_sram_req = 1'b1; inst_sram_wr = 1'b1; inst_sram_addr = 32'h1C00_0100;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("wr_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
            chk("wr_arvalid", {31'd0, arvalid}, 32'd0);
            tick();
        end
        inst_sram_wr = 1'b0;

        // reset while AR pending
        inst_sram_addr = 32'h1C00_0020;
        sample();
        chk("mid_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        tick();
        inst_sram_req = 1'b0;
        sample();
        chk("mid_arvalid", {31'd0, arvalid}, 32'd1);
        chk("mid_rready", {31'd0, rready}, 32'd1);
        resetn = 1'b0;
        tick();
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'h5555_AAAA;
        sample();
        chk("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("mid_rst_rready", {31'd0, rready}, 32'd0);
        chk("mid_rst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
        chk("mid_rst_araddr", araddr, 32'd0);
        tick();
        resetn = 1'b1; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0040;
        sample();
        chk("mid_after_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
        chk("stale_r_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        sample();
        chk("fresh_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
        exp_q.push_back(32'h1234_5678);
        tick();
        inst_sram_req = 1'b0; arready = 1'b1;
        sample();
        chk("fresh_araddr", araddr, 32'h1C00_0040);
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1234_5678;
        sample();
        chk_return("fresh");
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        sample();
        chk("end_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
